// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - default 640x480@60 timing constants (pixel clock = 50 MHz / 2)
//   - sync polarity codes
//   - axis_total(): total length of one axis (active + porches + sync)
//   - in_window(): half-open range test used for the active and sync windows
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_COLOR_W  = 2;
   localparam int DEF_CNT_W    = 10;

   // Level that hsync/vsync take while asserted.
   typedef enum bit {
      SYNC_ACTIVE_LOW  = 1'b0,
      SYNC_ACTIVE_HIGH = 1'b1
   } sync_pol_e;

   function automatic int axis_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // True when lo <= v < hi.
   function automatic bit in_window(input int v, input int lo, input int hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical). Counts 0..TOTAL-1 while en is high
// and decodes the active and sync windows from the current count.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset (count -> 0)
//   en      in   advance enable
//   cnt     out  current position, CNT_W bits
//   wrap    out  high when en is high and cnt is at TOTAL-1 (count wraps next)
//   active  out  cnt in [0, ACTIVE)
//   sync    out  cnt in [ACTIVE+FP, ACTIVE+FP+SYNC)
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL  = 800,
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int CNT_W  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             active,
   output logic             sync
);

   assign wrap   = en && (int'(cnt) == TOTAL - 1);
   assign active = in_window(int'(cnt), 0, ACTIVE);
   assign sync   = in_window(int'(cnt), ACTIVE + FP, ACTIVE + FP + SYNC);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing and pixel-output stage. A clock divider produces the
// pixel tick; horizontal/vertical axis counters give the raw timing (stage 0).
// Requests to the renderer are registered from stage 0; one pixel tick later
// the returned colour is registered onto the pins together with the syncs,
// which are delayed by the same amount (stage 1). Blanking forces colour to 0.
// Build option: define VGA_TEST_PATTERN_EN to add the test_mode input, which
// replaces renderer colour with 8 vertical colour bars.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   test_mode              (VGA_TEST_PATTERN_EN only) select colour bars
//   pix_req                one-clk strobe per active pixel tick
//   pix_x, pix_y           coordinates of the requested pixel
//   pix_r, pix_g, pix_b    renderer colour, sampled on the tick after pix_req
//   frame_start            one-clk strobe with the (0,0) request
//   line_start             one-clk strobe with each x=0 request
//   hsync, vsync           sync outputs, active level SYNC_POL
//   r, g, b                colour to the DAC
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int COLOR_W  = DEF_COLOR_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               test_mode,
`endif
   output logic               pix_req,
   output logic [CNT_W-1:0]   pix_x,
   output logic [CNT_W-1:0]   pix_y,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic               frame_start,
   output logic               line_start,
   output logic               hsync,
   output logic               vsync,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Pixel tick divider; with CLK_DIV=1 div stays 0 and tick is always high.
   logic [DIV_W-1:0] div;
   logic             tick;

   assign tick = (div == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst || tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Stage 0: raw timing counters.
   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;

   vga_axis_counter #(
      .TOTAL (H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .CNT_W(CNT_W)
   ) h_axis (
      .clk(clk), .rst(rst), .en(tick),
      .cnt(h_cnt), .wrap(h_wrap), .active(h_active), .sync(h_sync)
   );

   vga_axis_counter #(
      .TOTAL (V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .CNT_W(CNT_W)
   ) v_axis (
      .clk(clk), .rst(rst), .en(h_wrap),
      .cnt(v_cnt), .wrap(v_wrap), .active(v_active), .sync(v_sync)
   );

   // The vertical wrap has no consumer; frame_start is decoded from (0,0).
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;

   // Request registers plus the stage-0 flags that travel with the request
   // so stage 1 sees blanking/sync for the same pixel it is colouring.
   logic active_d, hsync_d, vsync_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_req     <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         active_d    <= 1'b0;
         hsync_d     <= 1'b0;
         vsync_d     <= 1'b0;
      end else begin
         pix_req     <= tick && h_active && v_active;
         line_start  <= tick && h_active && v_active && (h_cnt == '0);
         frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
         if (tick) begin
            active_d <= h_active && v_active;
            hsync_d  <= h_sync;
            vsync_d  <= v_sync;
            if (h_active && v_active) begin
               pix_x <= h_cnt;
               pix_y <= v_cnt;
            end
         end
      end
   end

   // Colour source for stage 1.
   logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
   // pix_x still holds the coordinate of the pixel being coloured here.
   logic [2:0] bar_idx;
   assign bar_idx = 3'((int'(pix_x) * 8) / H_ACTIVE);

   // NOTE: every output gets a default first so no path leaves a latch.
   always_comb begin
      src_r = pix_r;
      src_g = pix_g;
      src_b = pix_b;
      if (test_mode) begin
         src_r = {COLOR_W{bar_idx[0]}};
         src_g = {COLOR_W{bar_idx[1]}};
         src_b = {COLOR_W{bar_idx[2]}};
      end
   end
`else
   assign src_r = pix_r;
   assign src_g = pix_g;
   assign src_b = pix_b;
`endif

   // Stage 1: pins. Syncs and colour update on the same tick so their
   // relation is the one defined by the raw counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
         r     <= '0;
         g     <= '0;
         b     <= '0;
      end else if (tick) begin
         hsync <= hsync_d ? SYNC_POL : ~SYNC_POL;
         vsync <= vsync_d ? SYNC_POL : ~SYNC_POL;
         r     <= active_d ? src_r : '0;
         g     <= active_d ? src_g : '0;
         b     <= active_d ? src_b : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// dut_a: CLK_DIV=2, 640-pixel default horizontal timing, short vertical
//        timing (4 active lines, FP 1, sync 2, BP 1 -> 8 lines, 12800 clks).
// dut_b: CLK_DIV=1, 4x2 active, all porches/syncs 1 -> 7x5 = 35 clks/frame.
// Renderer model: pix_r = pix_x[1:0], pix_g = 3, pix_b = pix_y[1:0].
// Sample index n counts clock edges after reset is released; outputs are
// sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int CW  = 10;
   localparam int COL = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;

   logic           pix_req_a, frame_start_a, line_start_a, hsync_a, vsync_a;
   logic [CW-1:0]  pix_x_a, pix_y_a;
   logic [COL-1:0] pix_r_a, pix_g_a, pix_b_a, r_a, g_a, b_a;

   logic           pix_req_b, frame_start_b, line_start_b, hsync_b, vsync_b;
   logic [CW-1:0]  pix_x_b, pix_y_b;
   logic [COL-1:0] pix_r_b, pix_g_b, pix_b_b, r_b, g_b, b_b;

   assign pix_r_a = pix_x_a[1:0];
   assign pix_g_a = 2'd3;
   assign pix_b_a = pix_y_a[1:0];
   assign pix_r_b = pix_x_b[1:0];
   assign pix_g_b = 2'd3;
   assign pix_b_b = pix_y_b[1:0];

`ifdef VGA_TEST_PATTERN_EN
   logic test_mode_a, test_mode_b;
`endif

   vga_timing_gen #(
      .CLK_DIV(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_a (
      .clk(clk), .rst(rst_a),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(test_mode_a),
`endif
      .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
      .pix_r(pix_r_a), .pix_g(pix_g_a), .pix_b(pix_b_a),
      .frame_start(frame_start_a), .line_start(line_start_a),
      .hsync(hsync_a), .vsync(vsync_a), .r(r_a), .g(g_a), .b(b_a)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_b (
      .clk(clk), .rst(rst_b),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(test_mode_b),
`endif
      .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
      .pix_r(pix_r_b), .pix_g(pix_g_b), .pix_b(pix_b_b),
      .frame_start(frame_start_b), .line_start(line_start_b),
      .hsync(hsync_b), .vsync(vsync_b), .r(r_b), .g(g_b), .b(b_b)
   );

   typedef struct {
      int n;
      bit req; int x; int y;
      bit fs; bit ls; bit hs; bit vs;
      int r; int g; int b;
   } vec_t;

   vec_t va[$], vr[$], vb[$];
   int checks = 0;
   int errors = 0;
   int n = 0;

   function automatic vec_t mk(int n_i, bit req, int x, int y, bit fs, bit ls,
                               bit hs, bit vs, int r, int g, int b);
      return '{n_i, req, x, y, fs, ls, hs, vs, r, g, b};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string tag, input vec_t v,
         input logic req, input logic [CW-1:0] x, input logic [CW-1:0] y,
         input logic fs, input logic ls, input logic hs, input logic vs,
         input logic [COL-1:0] r, input logic [COL-1:0] g, input logic [COL-1:0] b);
      check({tag, ".pix_req"}, 32'(req), 32'(v.req));
      if (v.req) begin
         check({tag, ".pix_x"}, 32'(x), v.x);
         check({tag, ".pix_y"}, 32'(y), v.y);
      end
      check({tag, ".frame_start"}, 32'(fs), 32'(v.fs));
      check({tag, ".line_start"},  32'(ls), 32'(v.ls));
      check({tag, ".hsync"},       32'(hs), 32'(v.hs));
      check({tag, ".vsync"},       32'(vs), 32'(v.vs));
      check({tag, ".r"}, 32'(r), v.r);
      check({tag, ".g"}, 32'(g), v.g);
      check({tag, ".b"}, 32'(b), v.b);
   endtask

   task automatic chk_a(input string tag, input vec_t v);
      check_vec(tag, v, pix_req_a, pix_x_a, pix_y_a, frame_start_a, line_start_a,
                hsync_a, vsync_a, r_a, g_a, b_a);
   endtask

   task automatic chk_b(input string tag, input vec_t v);
      check_vec(tag, v, pix_req_b, pix_x_b, pix_y_b, frame_start_b, line_start_b,
                hsync_b, vsync_b, r_b, g_b, b_b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   function automatic int q_at(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   initial begin
      int   ia, ir, ib, req_cnt, fs_cnt, blank_bad, found;
      int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
      logic hs_prev, vs_prev;

      rst_a = 1'b1;
      rst_b = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      test_mode_a = 1'b0;
      test_mode_b = 1'b0;
`endif

      // dut_a main run:         n   req  x    y  fs ls hs vs  r  g  b
      va.push_back(mk(    1, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk(    2, 1,   0, 0, 1, 1, 1, 1, 0, 0, 0));
      va.push_back(mk(    3, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk(    4, 1,   1, 0, 0, 0, 1, 1, 0, 3, 0));
      va.push_back(mk(    5, 0,   0, 0, 0, 0, 1, 1, 0, 3, 0));
      va.push_back(mk(    6, 1,   2, 0, 0, 0, 1, 1, 1, 3, 0));
      va.push_back(mk(   10, 1,   4, 0, 0, 0, 1, 1, 3, 3, 0));
      va.push_back(mk(   12, 1,   5, 0, 0, 0, 1, 1, 0, 3, 0));
      va.push_back(mk( 1280, 1, 639, 0, 0, 0, 1, 1, 2, 3, 0));
      va.push_back(mk( 1282, 0,   0, 0, 0, 0, 1, 1, 3, 3, 0));
      va.push_back(mk( 1284, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk( 1314, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk( 1316, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0));
      va.push_back(mk( 1507, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0));
      va.push_back(mk( 1508, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk( 1602, 1,   0, 1, 0, 1, 1, 1, 0, 0, 0));
      va.push_back(mk( 1606, 1,   2, 1, 0, 0, 1, 1, 1, 3, 1));
      va.push_back(mk( 6402, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk( 8002, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk( 8004, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0));
      va.push_back(mk(11203, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0));
      va.push_back(mk(11204, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      va.push_back(mk(12802, 1,   0, 0, 1, 1, 1, 1, 0, 0, 0));
      va.push_back(mk(12806, 1,   2, 0, 0, 0, 1, 1, 1, 3, 0));

      // dut_a after a mid-frame reset (test pattern on when built with it).
      vr.push_back(mk(    1, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));
      vr.push_back(mk(    2, 1,   0, 0, 1, 1, 1, 1, 0, 0, 0));
`ifdef VGA_TEST_PATTERN_EN
      vr.push_back(mk(    4, 1,   1, 0, 0, 0, 1, 1, 0, 0, 0));
      vr.push_back(mk(  166, 1,  82, 0, 0, 0, 1, 1, 3, 0, 0));
      vr.push_back(mk( 1124, 1, 561, 0, 0, 0, 1, 1, 3, 3, 3));
`else
      vr.push_back(mk(    4, 1,   1, 0, 0, 0, 1, 1, 0, 3, 0));
      vr.push_back(mk(  166, 1,  82, 0, 0, 0, 1, 1, 1, 3, 0));
      vr.push_back(mk( 1124, 1, 561, 0, 0, 0, 1, 1, 0, 3, 0));
`endif
      vr.push_back(mk( 1284, 0,   0, 0, 0, 0, 1, 1, 0, 0, 0));

      // dut_b (tick every clk, 7x5 frame).
      vb.push_back(mk( 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0));
      vb.push_back(mk( 2, 1, 1, 0, 0, 0, 1, 1, 0, 3, 0));
      vb.push_back(mk( 4, 1, 3, 0, 0, 0, 1, 1, 2, 3, 0));
      vb.push_back(mk( 5, 0, 0, 0, 0, 0, 1, 1, 3, 3, 0));
      vb.push_back(mk( 6, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vb.push_back(mk( 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      vb.push_back(mk( 8, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0));
      vb.push_back(mk(11, 1, 3, 1, 0, 0, 1, 1, 2, 3, 1));
      vb.push_back(mk(22, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vb.push_back(mk(23, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vb.push_back(mk(29, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vb.push_back(mk(30, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vb.push_back(mk(36, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0));
      vb.push_back(mk(37, 1, 1, 0, 0, 0, 1, 1, 0, 3, 0));

      // Reset held for 10 clks: syncs inactive, colour and strobes low.
      repeat (10) @(posedge clk);
      #1;
      chk_a("A.in_reset", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

      rst_a = 1'b0;
      n = 0;
      ia = 0;
      req_cnt = 0;
      fs_cnt = 0;
      blank_bad = 0;
      hs_prev = 1'b1;
      vs_prev = 1'b1;
      for (int k = 0; k < 21000; k++) begin
         step();
         if (hs_prev === 1'b1 && hsync_a === 1'b0) hs_fall.push_back(n);
         if (hs_prev === 1'b0 && hsync_a === 1'b1) hs_rise.push_back(n);
         if (vs_prev === 1'b1 && vsync_a === 1'b0) vs_fall.push_back(n);
         if (vs_prev === 1'b0 && vsync_a === 1'b1) vs_rise.push_back(n);
         hs_prev = hsync_a;
         vs_prev = vsync_a;
         if (frame_start_a === 1'b1) fs_cnt++;
         if (n >= 2 && n <= 1601 && pix_req_a === 1'b1) req_cnt++;
         if (((n >= 1284 && n <= 1603) || (n >= 6404 && n <= 12803)) &&
             (r_a !== '0 || g_a !== '0 || b_a !== '0)) blank_bad++;
         if (ia < va.size() && va[ia].n == n) begin
            chk_a($sformatf("A@%0d", n), va[ia]);
            ia++;
         end
      end
      check("A.vectors_reached", ia, va.size());
      check("A.hsync_first_fall", q_at(hs_fall, 0), 1316);
      check("A.hsync_width", q_at(hs_rise, 0) - q_at(hs_fall, 0), 192);
      check("A.hsync_period", q_at(hs_fall, 1) - q_at(hs_fall, 0), 1600);
      check("A.vsync_first_fall", q_at(vs_fall, 0), 8004);
      check("A.vsync_width", q_at(vs_rise, 0) - q_at(vs_fall, 0), 3200);
      check("A.vsync_period", q_at(vs_fall, 1) - q_at(vs_fall, 0), 12800);
      check("A.frame_start_count", fs_cnt, 2);
      check("A.pix_req_per_line", req_cnt, 640);
      check("A.blank_colour_nonzero", blank_bad, 0);

      // Mid-frame reset at (320,2), one clk long.
      found = 0;
      for (int k = 0; k < 20000 && found == 0; k++) begin
         step();
         if (pix_req_a === 1'b1 && pix_x_a == 10'd320 && pix_y_a == 10'd2) found = 1;
      end
      check("A.reach_320_2", found, 1);
      rst_a = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      test_mode_a = 1'b1;
`endif
      step();
      chk_a("A.mid_reset", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      rst_a = 1'b0;
      n = 0;
      ir = 0;
      for (int k = 0; k < 1300; k++) begin
         step();
         if (ir < vr.size() && vr[ir].n == n) begin
            chk_a($sformatf("A.restart@%0d", n), vr[ir]);
            ir++;
         end
      end
      check("A.restart_vectors_reached", ir, vr.size());

      // dut_b: CLK_DIV=1, tiny frame.
      rst_b = 1'b0;
      n = 0;
      ib = 0;
      req_cnt = 0;
      fs_cnt = 0;
      for (int k = 0; k < 70; k++) begin
         step();
         if (n <= 35 && pix_req_b === 1'b1) req_cnt++;
         if (frame_start_b === 1'b1) fs_cnt++;
         if (ib < vb.size() && vb[ib].n == n) begin
            chk_b($sformatf("B@%0d", n), vb[ib]);
            ib++;
         end
      end
      check("B.vectors_reached", ib, vb.size());
      check("B.pix_req_per_frame", req_cnt, 8);
      check("B.frame_start_count", fs_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
